// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings for the transmitter and the
// receiver, plus a small parity helper.
//
// Contents:
//   tx_state_t    - 3-bit transmitter FSM encoding
//   rx_state_t    - 3-bit receiver FSM encoding
//   calc_parity() - XOR-reduce a byte, optionally inverted for odd parity
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        s_IDLE          = 3'b000,
        s_TX_START_BIT  = 3'b001,
        s_TX_DATA_BITS  = 3'b010,
        s_TX_PARITY_BIT = 3'b011,
        s_TX_STOP_BIT   = 3'b100,
        s_CLEANUP       = 3'b101
    } tx_state_t;

    typedef enum logic [2:0] {
        s_RX_IDLE       = 3'b000,
        s_RX_START_BIT  = 3'b001,
        s_RX_DATA_BITS  = 3'b010,
        s_RX_PARITY_BIT = 3'b011,
        s_RX_STOP_BIT   = 3'b100,
        s_RX_CLEANUP    = 3'b101
    } rx_state_t;

    function automatic logic calc_parity(input logic [7:0] i_data, input logic i_odd);
        return (^i_data) ^ i_odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-side handshake bundle of the UART transmitter.
//
// Signals:
//   i_Tx_DV     - byte-valid strobe (driver -> transmitter)
//   i_Tx_Byte   - byte to send      (driver -> transmitter)
//   o_Tx_Ready  - transmitter can accept a byte
//   o_Tx_Active - a frame is on the line
//   o_Tx_Serial - serial line, idle high
//   o_Tx_Done   - one-cycle pulse at frame end
// Modports: master = byte source, slave = transmitter.
interface uart_tx_if;

    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Ready;
    logic       o_Tx_Active;
    logic       o_Tx_Serial;
    logic       o_Tx_Done;

    modport master (
        output i_Tx_DV,
        output i_Tx_Byte,
        input  o_Tx_Ready,
        input  o_Tx_Active,
        input  o_Tx_Serial,
        input  o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV,
        input  i_Tx_Byte,
        output o_Tx_Ready,
        output o_Tx_Active,
        output o_Tx_Serial,
        output o_Tx_Done
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1
// while enabled and wraps to 0 on terminal count, so each bit boundary
// restarts the count without an explicit clear.
//
// Ports:
//   i_Clock  - clock, rising edge
//   i_Rst_L  - asynchronous active-low reset
//   i_En     - count enable
//   i_Clr    - synchronous clear (wins over enable)
//   o_Tc     - terminal count: last cycle of the current bit
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic i_En,
    input  logic i_Clr,
    output logic o_Tc
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_Count;
    logic             w_Tc;

    assign w_Tc = (r_Count == TC_VAL);
    assign o_Tc = w_Tc;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Count <= '0;
        end else if (i_Clr) begin
            r_Count <= '0;
        end else if (i_En) begin
            if (w_Tc) begin
                r_Count <= '0;
            end else begin
                r_Count <= r_Count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity,
// one or two stop bits. The serial line is registered; the handshake
// outputs are decodes of the state register.
//
// Ports:
//   i_Clock - clock, rising edge
//   i_Rst_L - asynchronous active-low reset
//   tx_if   - byte handshake and line outputs (uart_tx_if.slave)
//
// State             | meaning
// s_IDLE            | line high, ready; accept byte on i_Tx_DV
// s_TX_START_BIT    | line low for one bit time
// s_TX_DATA_BITS    | data bit r_Bit_Idx on the line, LSB first
// s_TX_PARITY_BIT   | parity of the latched byte (PARITY_EN only)
// s_TX_STOP_BIT     | line high for STOP_BITS bit times
// s_CLEANUP         | one cycle, o_Tx_Done high, then back to idle
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic     i_Clock,
    input  logic     i_Rst_L,
    uart_tx_if.slave tx_if
);

    localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

    tx_state_t  r_State;
    tx_state_t  w_State_Next;
    logic [2:0] r_Bit_Idx;
    logic [2:0] w_Bit_Idx_Next;
    logic [7:0] r_Tx_Byte;
    logic       r_Tx_Serial;
    logic       w_Serial_Next;
    logic       w_Load;
    logic       w_Timer_En;
    logic       w_Timer_Clr;
    logic       w_Bit_Tc;
    logic       w_Parity;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_Clock(i_Clock),
        .i_Rst_L(i_Rst_L),
        .i_En   (w_Timer_En),
        .i_Clr  (w_Timer_Clr),
        .o_Tc   (w_Bit_Tc)
    );

    assign w_Parity = calc_parity(r_Tx_Byte, (PARITY_ODD != 0));

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State     <= s_IDLE;
            r_Bit_Idx   <= '0;
            r_Tx_Byte   <= '0;
            r_Tx_Serial <= 1'b1;
        end else begin
            r_State     <= w_State_Next;
            r_Bit_Idx   <= w_Bit_Idx_Next;
            r_Tx_Serial <= w_Serial_Next;
            if (w_Load) begin
                r_Tx_Byte <= tx_if.i_Tx_Byte;
            end
        end
    end

    // r_Bit_Idx counts data bits in the data state and stop bits in the
    // stop state, so the bit timer never needs more than one bit's width.
    always_comb begin
        w_State_Next   = r_State;
        w_Bit_Idx_Next = r_Bit_Idx;
        w_Load         = 1'b0;
        w_Timer_En     = 1'b0;
        w_Timer_Clr    = 1'b0;
        case (r_State)
            s_IDLE: begin
                w_Timer_Clr    = 1'b1;
                w_Bit_Idx_Next = '0;
                if (tx_if.i_Tx_DV) begin
                    w_Load       = 1'b1;
                    w_State_Next = s_TX_START_BIT;
                end
            end
            s_TX_START_BIT: begin
                w_Timer_En = 1'b1;
                if (w_Bit_Tc) begin
                    w_Bit_Idx_Next = '0;
                    w_State_Next   = s_TX_DATA_BITS;
                end
            end
            s_TX_DATA_BITS: begin
                w_Timer_En = 1'b1;
                if (w_Bit_Tc) begin
                    if (r_Bit_Idx == LAST_DATA_IDX) begin
                        w_Bit_Idx_Next = '0;
                        w_State_Next   = (PARITY_EN != 0) ? s_TX_PARITY_BIT : s_TX_STOP_BIT;
                    end else begin
                        w_Bit_Idx_Next = r_Bit_Idx + 3'd1;
                    end
                end
            end
            s_TX_PARITY_BIT: begin
                w_Timer_En = 1'b1;
                if (w_Bit_Tc) begin
                    w_Bit_Idx_Next = '0;
                    w_State_Next   = s_TX_STOP_BIT;
                end
            end
            s_TX_STOP_BIT: begin
                w_Timer_En = 1'b1;
                if (w_Bit_Tc) begin
                    if (r_Bit_Idx == LAST_STOP_IDX) begin
                        w_Bit_Idx_Next = '0;
                        w_State_Next   = s_CLEANUP;
                    end else begin
                        w_Bit_Idx_Next = r_Bit_Idx + 3'd1;
                    end
                end
            end
            s_CLEANUP: begin
                w_Timer_Clr    = 1'b1;
                w_Bit_Idx_Next = '0;
                w_State_Next   = s_IDLE;
            end
            default: begin
                w_Timer_Clr    = 1'b1;
                w_Bit_Idx_Next = '0;
                w_State_Next   = s_IDLE;
            end
        endcase
    end

    // The line value is chosen from the next state so the registered output
    // changes on the same edge as the state it belongs to.
    always_comb begin
        w_Serial_Next = 1'b1;
        case (w_State_Next)
            s_TX_START_BIT:  w_Serial_Next = 1'b0;
            s_TX_DATA_BITS:  w_Serial_Next = r_Tx_Byte[w_Bit_Idx_Next];
            s_TX_PARITY_BIT: w_Serial_Next = w_Parity;
            default:         w_Serial_Next = 1'b1;
        endcase
    end

    assign tx_if.o_Tx_Serial = r_Tx_Serial;
    assign tx_if.o_Tx_Ready  = (r_State == s_IDLE);
    assign tx_if.o_Tx_Done   = (r_State == s_CLEANUP);
    assign tx_if.o_Tx_Active = (r_State == s_TX_START_BIT)  ||
                               (r_State == s_TX_DATA_BITS)  ||
                               (r_State == s_TX_PARITY_BIT) ||
                               (r_State == s_TX_STOP_BIT);

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning i_Clock cycles per serial bit; legal range >= 2.
REQ-002 SHALL have parameter PARITY_EN, default 0; 1 inserts a parity bit after the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
REQ-004 SHALL have parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port i_Clock, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port i_Rst_L, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port i_Tx_DV, input, 1 bit: byte-valid strobe.
REQ-009 SHALL have port i_Tx_Byte, input, 8 bits: byte to send.
REQ-010 SHALL have port o_Tx_Ready, output, 1 bit: high when a byte can be accepted.
REQ-011 SHALL have port o_Tx_Active, output, 1 bit: high while a frame is on the line.
REQ-012 SHALL have port o_Tx_Serial, output, 1 bit: serial line, idle high.
REQ-013 SHALL have port o_Tx_Done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-014 SHALL use a state machine with states s_IDLE, s_TX_START_BIT, s_TX_DATA_BITS, s_TX_PARITY_BIT, s_TX_STOP_BIT and s_CLEANUP; unreachable encodings SHALL go to s_IDLE.
REQ-015 s_IDLE: SHALL hold o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, clock counter=0 and bit index=0.
REQ-016 A byte SHALL be accepted only at a rising edge where state=s_IDLE and i_Tx_DV=1; at that edge i_Tx_Byte is latched and the state moves to s_TX_START_BIT.
REQ-017 i_Tx_DV in any state other than s_IDLE SHALL be ignored; the latched byte SHALL NOT change mid-frame.
REQ-018 o_Tx_Serial SHALL be registered; the start bit (0) SHALL appear in the cycle after the accept edge.
REQ-019 Each bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-020 The clock counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1 and reset to 0 at each bit boundary.
REQ-021 Data bits SHALL be sent LSB first, bit index 0..7; after index 7 completes, the state moves to s_TX_PARITY_BIT if PARITY_EN=1, else to s_TX_STOP_BIT.
REQ-022 The parity bit SHALL be XOR of the latched byte, inverted when PARITY_ODD=1.
REQ-023 s_TX_STOP_BIT SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles, then move to s_CLEANUP.
REQ-024 s_CLEANUP SHALL last one cycle with o_Tx_Done=1, o_Tx_Serial=1 and o_Tx_Active=0, then move to s_IDLE.
REQ-025 o_Tx_Ready SHALL be low from the accept edge until re-entry to s_IDLE.
REQ-026 Total time from accept edge to the o_Tx_Done pulse SHALL be (9+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-027 A byte presented during the o_Tx_Done cycle SHALL be ignored; minimum inter-frame gap is 1 idle cycle.
REQ-028 o_Tx_Active SHALL be 1 in the start, data, parity and stop states.

Reset
REQ-029 While i_Rst_L=0, regardless of clock, the block SHALL force: state=s_IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, counters=0, latched byte=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately with no o_Tx_Done pulse.
REQ-031 Reset deassertion SHALL take effect at the next rising edge; the block SHALL accept i_Tx_DV at the first edge after deassertion.

Structure
REQ-032 State encodings (3-bit) SHALL live in shared package uart_pkg, alongside the receiver state encodings.
REQ-033 Bit timing MAY be factored into sub-module uart_bit_timer (count enable, clear, terminal-count output); all other logic SHALL be in uart_tx.

Verification
REQ-034 CLKS_PER_BIT=4, defaults, i_Tx_DV=1 with 8'hA5 for one cycle -> o_Tx_Serial = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; o_Tx_Done pulses 40 cycles after the accept edge.
REQ-035 PARITY_EN=1, PARITY_ODD=0, byte 8'hA5 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; frame length 44 cycles.
REQ-036 STOP_BITS=2, byte 8'h00 -> line high for 8 cycles after the data bits; done at cycle 44.
REQ-037 i_Tx_DV pulsed with 8'hFF in data-bit 3 of an 8'h0F frame -> 8'h0F sent unchanged; the 8'hFF is never sent.
REQ-038 i_Rst_L low at cycle 13 of a frame -> o_Tx_Serial=1 and o_Tx_Ready=1 immediately; no o_Tx_Done pulse; next byte 8'h3C sent correctly after release.
REQ-039 Back-to-back: i_Tx_DV held high continuously -> frames separated by exactly one s_CLEANUP cycle plus one s_IDLE cycle; each frame bit-exact.
